// File: rtl/line_tx_pkg.sv
// line_tx_pkg: FSM state type and width helpers shared by the line transmit scheduler
package line_tx_pkg;
   typedef enum logic [2:0] {IDLE, TRIG, WAIT_UP, WAIT_DN, ACK} state_e;
   function automatic int idx_width(input int id_w, input int cnt_w, input int row_w);
      return id_w + cnt_w + row_w;
   endfunction
   function automatic int to_width(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction
endpackage

// File: rtl/row_fifo.sv
// row_fifo: per-channel row queue with a registered head
// Ports: clk/rstn clock and async active-low reset; push/din enqueue a row,
// pop dequeues; full/empty status; head is the oldest row, valid when !empty.
// A push to a full queue is accepted only when a pop happens on the same edge.
module row_fifo #(
   parameter int DEPTH = 4,
   parameter int ROW_W = 11
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [ROW_W-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [ROW_W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   logic [ROW_W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic [ROW_W-1:0] head_q, head_d;
   logic do_push, do_pop;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign head = head_q;
   always_comb begin
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      head_d = head_q;
      // the next head is either the following stored row or, when the queue
      // is (or becomes) empty, the row being written this edge
      if (do_pop) head_d = (cnt_q == 1) ? din : mem_q[rd_q + 1'b1];
      else if (empty) head_d = din;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         head_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         head_q <= head_d;
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/line_tx_scheduler.sv
// line_tx_scheduler: round-robin scheduler of per-line UDP transmissions from CH_NUM line buffers
// Ports: clk/rstn clock and async active-low reset; en gates new grants;
// line_valid/line_rows queue one row per pulsing channel; tx_busy is the
// transmitter handshake; trig/index start a packet {id, cnt, row};
// line_ack releases a sent line; overflow is a sticky drop flag cleared by
// ovf_clr; timeout_err pulses when tx_busy never rose; busy is high outside IDLE.
module line_tx_scheduler
   import line_tx_pkg::*;
#(
   parameter int CH_NUM = 2,
   parameter int ROW_W = 11,
   parameter int CNT_W = 4,
   parameter int ID_W = 3,
   parameter int DEPTH = 4,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      en,
   input  logic [CH_NUM-1:0]         line_valid,
   input  logic [CH_NUM*ROW_W-1:0]   line_rows,
   input  logic                      tx_busy,
   output logic                      trig,
   output logic [ID_W+CNT_W+ROW_W-1:0] index,
   output logic [CH_NUM-1:0]         line_ack,
   output logic [CH_NUM-1:0]         overflow,
   input  logic                      ovf_clr,
   output logic                      timeout_err,
   output logic                      busy
);
   localparam int PW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
   localparam int IW = idx_width(ID_W, CNT_W, ROW_W);
   localparam int TW = to_width(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   state_e state_q, state_d;
   logic [PW-1:0] g_q, g_d, rr_q, rr_d, win;
   logic [IW-1:0] index_q, index_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [CNT_W-1:0] seq_q [CH_NUM];
   logic [CNT_W-1:0] seq_d [CH_NUM];
   logic [CH_NUM-1:0] ack_q, ack_d, ovf_q, ovf_d;
   logic trig_q, trig_d, to_q, to_d, busy_q;
   logic [CH_NUM-1:0] full, empty, pop, drop;
   logic [ROW_W-1:0] head [CH_NUM];
   int c;
   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      assign pop[k] = (state_q == ACK) && (g_q == PW'(k));
      row_fifo #(.DEPTH(DEPTH), .ROW_W(ROW_W)) u_fifo (
         .clk(clk),
         .rstn(rstn),
         .push(line_valid[k]),
         .din(line_rows[k*ROW_W +: ROW_W]),
         .pop(pop[k]),
         .full(full[k]),
         .empty(empty[k]),
         .head(head[k])
      );
   end
   assign drop = line_valid & full & ~pop;
   assign trig = trig_q;
   assign index = index_q;
   assign line_ack = ack_q;
   assign overflow = ovf_q;
   assign timeout_err = to_q;
   assign busy = busy_q;
   // scan from the farthest offset back to rr_ptr so the nearest non-empty
   // channel at or after rr_ptr is the last one written
   always_comb begin
      c = 0;
      win = rr_q;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         c = int'(rr_q) + i;
         c = (c >= CH_NUM) ? c - CH_NUM : c;
         if (!empty[c]) win = PW'(c);
      end
   end
   // the timeout counter is cleared on grant and counts from the TRIG cycle,
   // so timeout_err rises TIMEOUT cycles after trig
   always_comb begin
      state_d = state_q;
      g_d = g_q;
      index_d = index_q;
      rr_d = rr_q;
      tcnt_d = tcnt_q;
      seq_d = seq_q;
      trig_d = 1'b0;
      ack_d = '0;
      to_d = 1'b0;
      case (state_q)
         IDLE:
            if (en && !(&empty)) begin
               state_d = TRIG;
               g_d = win;
               trig_d = 1'b1;
               tcnt_d = '0;
               index_d = {ID_W'(win), seq_q[win], head[win]};
            end
         TRIG: begin
            state_d = WAIT_UP;
            tcnt_d = tcnt_q + 1'b1;
         end
         WAIT_UP:
            if (tx_busy) state_d = WAIT_DN;
            else if (tcnt_q == TO_LAST) begin
               state_d = IDLE;
               to_d = 1'b1;
            end else tcnt_d = tcnt_q + 1'b1;
         WAIT_DN:
            if (!tx_busy) begin
               state_d = ACK;
               ack_d = CH_NUM'(1) << g_q;
            end
         ACK: begin
            state_d = IDLE;
            seq_d[g_q] = seq_q[g_q] + 1'b1;
            rr_d = (g_q == PW'(CH_NUM - 1)) ? '0 : g_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      ovf_d = drop | (ovf_q & ~{CH_NUM{ovf_clr}});
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q <= IDLE;
         g_q <= '0;
         rr_q <= '0;
         index_q <= '0;
         tcnt_q <= '0;
         seq_q <= '{default: '0};
         ack_q <= '0;
         ovf_q <= '0;
         trig_q <= 1'b0;
         to_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q <= g_d;
         rr_q <= rr_d;
         index_q <= index_d;
         tcnt_q <= tcnt_d;
         seq_q <= seq_d;
         ack_q <= ack_d;
         ovf_q <= ovf_d;
         trig_q <= trig_d;
         to_q <= to_d;
         busy_q <= state_d != IDLE;
      end
endmodule

// File: tb/tb_line_tx_scheduler.sv
// tb_line_tx_scheduler: scoreboard bench for line_tx_scheduler (2 channels, TIMEOUT=16)
module tb_line_tx_scheduler;
   localparam int CH = 2, RW = 11, CW = 4, IDW = 3, IW = IDW + CW + RW;
   logic clk = 1'b0, rstn = 1'b0, en = 1'b1, tx_busy = 1'b0, ovf_clr = 1'b0;
   logic [CH-1:0] line_valid = '0;
   logic [CH*RW-1:0] line_rows = '0;
   logic trig, timeout_err, busy;
   logic [IW-1:0] index;
   logic [CH-1:0] line_ack, overflow;
   int total = 0, bad = 0;
   logic [IW-1:0] exp_idx [$];
   logic [CH-1:0] exp_ack [$];
   logic [IW-1:0] e_idx;
   logic [CH-1:0] e_ack;
   line_tx_scheduler #(.CH_NUM(CH), .ROW_W(RW), .CNT_W(CW), .ID_W(IDW), .DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rstn(rstn), .en(en), .line_valid(line_valid), .line_rows(line_rows),
      .tx_busy(tx_busy), .trig(trig), .index(index), .line_ack(line_ack),
      .overflow(overflow), .ovf_clr(ovf_clr), .timeout_err(timeout_err), .busy(busy)
   );
   always #5 clk = ~clk;
   function automatic logic [IW-1:0] mk(input int ch, input int seq, input int row);
      return {IDW'(ch), CW'(seq), RW'(row)};
   endfunction
   always @(negedge clk) begin
      if (rstn && trig) begin
         total++;
         if (exp_idx.size() == 0) begin
            bad++;
            $display("FAIL trig_unexpected: got index %0h want no trig", index);
         end else begin
            e_idx = exp_idx.pop_front();
            if (index !== e_idx) begin
               bad++;
               $display("FAIL sb_index: got %0h want %0h", index, e_idx);
            end
         end
      end
      if (rstn && line_ack !== '0) begin
         total++;
         if (exp_ack.size() == 0) begin
            bad++;
            $display("FAIL ack_unexpected: got %b want none", line_ack);
         end else begin
            e_ack = exp_ack.pop_front();
            if (line_ack !== e_ack) begin
               bad++;
               $display("FAIL sb_ack: got %b want %b", line_ack, e_ack);
            end
         end
      end
   end
   task automatic do_reset();
      rstn = 1'b0;
      en = 1'b1;
      tx_busy = 1'b0;
      ovf_clr = 1'b0;
      line_valid = '0;
      exp_idx.delete();
      exp_ack.delete();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
   endtask
   task automatic pulse(input logic [CH-1:0] m, input int r0, input int r1);
      line_valid = m;
      line_rows = {RW'(r1), RW'(r0)};
      @(posedge clk);
      #1 line_valid = '0;
      ovf_clr = 1'b0;
   endtask
   task automatic xmit(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (trig) ok = 1'b1;
      end
      if (!ok) return;
      @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 tx_busy = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (line_ack !== '0) ok = 1'b1;
      end
   endtask
   task automatic test_reset();
      rstn = 1'b0;
      #2;
      total++;
      if ({trig, index, line_ack, overflow, timeout_err, busy} !== '0) begin
         bad++;
         $display("FAIL reset_assert: got %0h want 0", {trig, index, line_ack, overflow, timeout_err, busy});
      end
      do_reset();
      @(negedge clk);
      total++;
      if ({trig, index, line_ack, overflow, timeout_err, busy} !== '0) begin
         bad++;
         $display("FAIL reset_release: got %0h want 0", {trig, index, line_ack, overflow, timeout_err, busy});
      end
   endtask
   task automatic test_single();
      do_reset();
      exp_idx.push_back(mk(0, 0, 5));
      exp_ack.push_back(2'b01);
      pulse(2'b01, 5, 0);
      @(negedge clk);
      total++;
      if (trig !== 1'b0) begin bad++; $display("FAIL single_trig_early: got %b want 0", trig); end
      @(negedge clk);
      total++;
      if (trig !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_trig_latency: got trig=%b busy=%b want 1 1", trig, busy); end
      @(negedge clk);
      total++;
      if (trig !== 1'b0) begin bad++; $display("FAIL single_trig_width: got %b want 0", trig); end
      #4 tx_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 tx_busy = 1'b0;
      @(negedge clk);
      total++;
      if (line_ack !== 2'b00) begin bad++; $display("FAIL single_ack_early: got %b want 00", line_ack); end
      @(negedge clk);
      total++;
      if (line_ack !== 2'b01 || index !== mk(0, 0, 5)) begin bad++; $display("FAIL single_ack: got %b/%0h want 01/%0h", line_ack, index, mk(0, 0, 5)); end
      @(negedge clk);
      total++;
      if (line_ack !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL single_done: got ack=%b busy=%b want 00 0", line_ack, busy); end
   endtask
   task automatic test_round_robin();
      bit ok;
      do_reset();
      exp_idx.push_back(mk(0, 0, 10));
      exp_idx.push_back(mk(1, 0, 20));
      exp_idx.push_back(mk(0, 1, 11));
      exp_idx.push_back(mk(1, 1, 21));
      for (int i = 0; i < 4; i++) exp_ack.push_back(i % 2 == 0 ? 2'b01 : 2'b10);
      pulse(2'b11, 10, 20);
      pulse(2'b11, 11, 21);
      for (int i = 0; i < 4; i++) begin
         xmit(ok);
         total++;
         if (!ok) begin bad++; $display("FAIL rr_xmit%0d: got no handshake want trig and ack", i); end
      end
      total++;
      if (exp_idx.size() != 0) begin bad++; $display("FAIL rr_left: got %0d pending want 0", exp_idx.size()); end
   endtask
   task automatic test_overflow();
      bit ok;
      int n;
      do_reset();
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_idx.push_back(mk(1, i, 100 + i));
         exp_ack.push_back(2'b10);
         pulse(2'b10, 0, 100 + i);
      end
      @(negedge clk);
      total++;
      if (overflow !== 2'b00) begin bad++; $display("FAIL ovf_early: got %b want 00", overflow); end
      ovf_clr = 1'b1;
      pulse(2'b10, 0, 104);
      @(negedge clk);
      total++;
      if (overflow !== 2'b10) begin bad++; $display("FAIL ovf_set_wins: got %b want 10", overflow); end
      total++;
      if (trig !== 1'b0) begin bad++; $display("FAIL ovf_en_gate: got trig %b want 0", trig); end
      @(posedge clk);
      #1 ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      @(negedge clk);
      total++;
      if (overflow !== 2'b00) begin bad++; $display("FAIL ovf_clr: got %b want 00", overflow); end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         xmit(ok);
         total++;
         if (!ok) begin bad++; $display("FAIL ovf_xmit%0d: got no handshake want trig and ack", i); end
      end
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (trig) n++;
      end
      total++;
      if (n != 0 || exp_idx.size() != 0) begin bad++; $display("FAIL ovf_extra: got %0d trigs %0d pending want 0 0", n, exp_idx.size()); end
   endtask
   task automatic test_timeout();
      bit ok;
      int k;
      do_reset();
      exp_idx.push_back(mk(0, 0, 7));
      exp_idx.push_back(mk(0, 0, 7));
      exp_ack.push_back(2'b01);
      pulse(2'b01, 7, 0);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (trig) ok = 1'b1;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL to_first_trig: got none want trig"); end
      k = 0;
      for (int i = 1; i <= 40 && k == 0; i++) begin
         @(negedge clk);
         if (timeout_err) k = i;
      end
      total++;
      if (k != 16) begin bad++; $display("FAIL to_delay: got %0d cycles want 16", k); end
      xmit(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL to_retrig: got no handshake want retrigger and ack"); end
   endtask
   task automatic test_seq_wrap();
      bit ok;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         exp_idx.push_back(mk(0, i % 16, 200 + i));
         exp_ack.push_back(2'b01);
         pulse(2'b01, 200 + i, 0);
         xmit(ok);
         total++;
         if (!ok) begin bad++; $display("FAIL wrap_xmit%0d: got no handshake want trig and ack", i); end
      end
      total++;
      if (index[RW +: CW] !== '0) begin bad++; $display("FAIL wrap_cnt: got %0d want 0", index[RW +: CW]); end
   endtask
   task automatic test_reset_mid();
      bit ok;
      int n;
      do_reset();
      exp_idx.push_back(mk(0, 0, 9));
      pulse(2'b11, 9, 3);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (trig) ok = 1'b1;
      end
      @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (!ok || busy !== 1'b1) begin bad++; $display("FAIL mid_setup: got trig_seen=%b busy=%b want 1 1", ok, busy); end
      rstn = 1'b0;
      #1;
      total++;
      if ({trig, index, line_ack, overflow, timeout_err, busy} !== '0) begin
         bad++;
         $display("FAIL mid_reset_outs: got %0h want 0", {trig, index, line_ack, overflow, timeout_err, busy});
      end
      exp_idx.delete();
      exp_ack.delete();
      repeat (2) @(posedge clk);
      #1 tx_busy = 1'b0;
      rstn = 1'b1;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (trig) n++;
      end
      total++;
      if (n != 0) begin bad++; $display("FAIL mid_no_trig: got %0d trigs want 0", n); end
      exp_idx.push_back(mk(1, 0, 4));
      exp_ack.push_back(2'b10);
      pulse(2'b10, 0, 4);
      xmit(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL mid_after: got no handshake want trig and ack"); end
      repeat (10) @(negedge clk);
      total++;
      if (exp_idx.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL mid_empty: got %0d pending busy=%b want 0 0", exp_idx.size(), busy); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_overflow();
      test_timeout();
      test_seq_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/line_tx_scheduler.md
Name: line_tx_scheduler

Overview:
- Parametrised successor to the fixed two-camera UDP line path: schedules per-line UDP transmissions from CH_NUM camera line buffers.
- Each channel has a small row queue; the block arbitrates round-robin and drives the UDP transmitter trigger and packet index.
- Handshakes on the transmitter busy flag and recovers from a stalled transmitter via timeout.
- Sits in the rgmii_clk domain, between the line buffers and udp_packet.

Parameters:
- CH_NUM, 2: number of camera channels (1..8).
- ROW_W, 11: row number width.
- CNT_W, 4: per-channel sequence counter width.
- ID_W, 3: channel id field width; CH_NUM <= 2**ID_W.
- DEPTH, 4: per-channel row queue depth (power of 2, >= 2).
- TIMEOUT, 1_000_000: clk cycles allowed for busy to rise after trig.

Ports:
- clk  in  1  rgmii_clk domain clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  global enable; low blocks new grants.
- line_valid  in  CH_NUM  per-channel one-cycle pulse: one line ready.
- line_rows  in  CH_NUM*ROW_W  row of each pulsing channel; channel k occupies bits [k*ROW_W +: ROW_W].
- tx_busy  in  1  transmitter busy.
- trig  out  1  one-cycle start pulse to the transmitter.
- index  out  ID_W+CNT_W+ROW_W  packet index {id, cnt, row}; held stable from trig until ack.
- line_ack  out  CH_NUM  one-cycle pulse: line of channel k sent, buffer release.
- overflow  out  CH_NUM  sticky per-channel drop flag.
- ovf_clr  in  1  clears overflow.
- timeout_err  out  1  one-cycle pulse on timeout.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs 0, queues empty, sequence counters 0, round-robin pointer 0, state IDLE.
- Queues: line_valid[k] pushes line_rows[k] into queue k at the same edge.
  - Push to a full queue: the row is dropped and overflow[k] is set.
  - Push and pop on the same edge to a full queue is accepted (no drop).
  - ovf_clr on the same edge as a new overflow: the set wins.
- FSM states: IDLE, TRIG, WAIT_UP, WAIT_DN, ACK.
- IDLE:
  - Transition: if en and any queue is non-empty, register the winner g, go to TRIG.
  - Winner: the first non-empty channel at or after rr_ptr, wrapping.
  - On grant, register index = {g, seq[g], head row of queue g}.
- TRIG: trig=1 for exactly one cycle; clear the timeout counter; go to WAIT_UP.
- WAIT_UP:
  - tx_busy=1 goes to WAIT_DN.
  - Counter reaching TIMEOUT-1 without busy: pulse timeout_err, go to IDLE with no pop. The same line is re-arbitrated and rr_ptr is unchanged.
- WAIT_DN: tx_busy=0 goes to ACK. No timeout in this state.
- ACK (one cycle):
  - line_ack[g]=1; pop queue g; seq[g] += 1 (wraps mod 2**CNT_W).
  - rr_ptr = g+1 mod CH_NUM; go to IDLE.
- Latency: line_valid at edge t with empty queues and IDLE gives the grant at t+1 and trig high during cycle t+2.
- Fairness: each channel waits at most CH_NUM-1 transfers.
- en low mid-transfer: the current transfer completes; only IDLE grants are gated.
- Reset mid-transfer: immediate return to reset values; queued rows are lost.
- ID_W width: the id field is zero-extended channel number.

Decomposition:
- Package line_tx_pkg holds: the state enum (state_e), the index field width function, and the TIMEOUT counter width derived via $clog2.
- One sub-module, row_fifo: a synchronous queue with DEPTH x ROW_W storage, push/pop/full/empty, and a registered head output.
- Instantiate row_fifo CH_NUM times in a generate loop.

Test Plan:
1. Single line: CH_NUM=2, line_valid=2'b01, row=5. Expect trig at +2 with index={0,0,5}. Raise busy 3 cycles, drop. Expect line_ack=2'b01 one cycle after busy falls, then busy=0.
2. Round-robin: both channels pulse rows 10/20 on the same edge, twice (rows 11/21). Expected send order is ch0:10, ch1:20, ch0:11, ch1:21. Expected cnt fields are 0, 0, 1, 1.
3. Overflow: 5 pulses to ch1 with DEPTH=4 while en=0. Expected overflow=2'b10 and four queued rows. ovf_clr clears it; en=1 then sends exactly 4 lines.
4. Timeout: TIMEOUT=16, tx_busy held 0. Expect timeout_err 16 cycles after trig, then a retrigger of the same index with no line_ack.
5. Sequence wrap: 17 ch0 lines with CNT_W=4. The 17th index has cnt=0.
6. Reset mid-transfer: rstn low during WAIT_DN. Expect all outputs 0 and queues empty; after release, no trig until a new line_valid arrives.
